// File: rtl/matmul_operand_loader.sv
// ============================================================================
// Module  : matmul_operand_loader
// Purpose : Captures A then B (row-major byte stream) for the matrix engine,
//           fires a start pulse and holds operands until the engine is done.
//           Optional macro LOADER_TRANSPOSE_B_EN: the B stream is column-major.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_operand_loader #(
  parameter int DATA_W = 8,
  parameter int N      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [N*N*DATA_W-1:0]      a_flat,
  output logic [N*N*DATA_W-1:0]      b_flat,
  output logic                       mm_start,
  input  logic                       mm_done,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr,
  output logic [7:0]                 frame_cnt
);

  localparam int                ELEMS    = N * N;
  localparam int                IDX_W    = $clog2(ELEMS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ELEMS - 1);

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   b_pos;
  logic               xfer, last_idx, frame_err, wr_a, wr_b;
  logic [DATA_W-1:0]  a_mem [ELEMS];
  logic [DATA_W-1:0]  b_mem [ELEMS];

  assign s_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign mm_start = (state == FIRE);
  assign busy     = (state == FIRE) || (state == WAIT_DONE);
  assign xfer     = s_valid && s_ready;
  assign last_idx = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    frame_err = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    case (state)
      LOAD_A: begin
        if (xfer) begin
          // s_last can never be legal while A is still loading
          if (s_last) begin
            frame_err = 1'b1;
            idx_nxt   = '0;
          end else begin
            wr_a = 1'b1;
            if (last_idx) begin
              state_nxt = LOAD_B;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          if (s_last != last_idx) begin
            frame_err = 1'b1;
            state_nxt = LOAD_A;
            idx_nxt   = '0;
          end else begin
            wr_b = 1'b1;
            if (last_idx) begin
              state_nxt = FIRE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      FIRE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (mm_done) begin
          state_nxt = LOAD_A;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = LOAD_A;
    endcase
  end

`ifdef LOADER_TRANSPOSE_B_EN
  always_comb b_pos = IDX_W'((int'(idx) % N) * N + int'(idx) / N);
`else
  always_comb b_pos = idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < ELEMS; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < ELEMS; e++) begin
        if (wr_a && (idx == IDX_W'(e)))   a_mem[e] <= s_data;
        if (wr_b && (b_pos == IDX_W'(e))) b_mem[e] <= s_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < ELEMS; g++) begin : g_pack
      assign a_flat[DATA_W*g +: DATA_W] = a_mem[g];
      assign b_flat[DATA_W*g +: DATA_W] = b_mem[g];
    end
  endgenerate

  // Set wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (frame_err)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
      if (state == FIRE) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_operand_loader.sv
// ============================================================================
// Module  : tb_matmul_operand_loader
// Purpose : Self-checking bench for matmul_operand_loader (frame-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_operand_loader;

  localparam int E     = 16;
  localparam int FRAME = 2 * E;

  logic         clk = 1'b0;
  logic         rst, s_valid, s_last, err_clr, mm_done;
  logic [7:0]   s_data;
  logic         s_ready, mm_start, busy, err;
  logic [7:0]   frame_cnt;
  logic [127:0] a_flat, b_flat;

  always #5 clk = ~clk;

  matmul_operand_loader #(.DATA_W(8), .N(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .a_flat(a_flat), .b_flat(b_flat), .mm_start(mm_start),
    .mm_done(mm_done), .busy(busy), .err(err), .err_clr(err_clr),
    .frame_cnt(frame_cnt)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: phase 0 = accepting beats, 1 = start cycle, 2 = waiting
  int         m_phase, m_pos, fires_seen;
  logic [7:0] m_a [E];
  logic [7:0] m_b [E];
  logic       m_err;
  logic [7:0] m_cnt;

  typedef struct {
    int   kind;
    int   vprob;
    int   last_at;
    int   nbeats;
    int   delay;
    int   fire;
    logic exp_err;
    int   exp_cnt;
    logic clr;
  } row_t;

  row_t rows [8];

  task automatic check1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int b_elem(input int k);
`ifdef LOADER_TRANSPOSE_B_EN
    return (k % 4) * 4 + k / 4;
`else
    return k;
`endif
  endfunction

  function automatic logic [127:0] pack_a();
    logic [127:0] v;
    for (int i = 0; i < E; i++) v[8*i +: 8] = m_a[i];
    return v;
  endfunction

  function automatic logic [127:0] pack_b();
    logic [127:0] v;
    for (int i = 0; i < E; i++) v[8*i +: 8] = m_b[i];
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pos   = 0;
    m_err   = 1'b0;
    m_cnt   = 8'd0;
    for (int i = 0; i < E; i++) begin
      m_a[i] = 8'd0;
      m_b[i] = 8'd0;
    end
  endtask

  // Advance the model with the current inputs, clock once, compare everything
  task automatic tick();
    logic set_err;
    set_err = 1'b0;
    case (m_phase)
      0: if (s_valid) begin
        if (s_last != (m_pos == FRAME - 1)) begin
          set_err = 1'b1;
          m_pos   = 0;
        end else begin
          if (m_pos < E) m_a[m_pos] = s_data;
          else           m_b[b_elem(m_pos - E)] = s_data;
          if (m_pos == FRAME - 1) begin
            m_phase = 1;
            m_pos   = 0;
          end else begin
            m_pos++;
          end
        end
      end
      1: begin
        m_phase = 2;
        m_cnt   = m_cnt + 8'd1;
      end
      default: if (mm_done) m_phase = 0;
    endcase
    if (set_err)      m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    @(posedge clk);
    #1;
    if (mm_start === 1'b1) fires_seen++;
    check1("s_ready", s_ready, m_phase == 0);
    check1("mm_start", mm_start, m_phase == 1);
    check1("busy", busy, m_phase != 0);
    check1("err", err, m_err);
    check8("frame_cnt", frame_cnt, m_cnt);
    check128("a_flat", a_flat, pack_a());
    check128("b_flat", b_flat, pack_b());
  endtask

  function automatic logic [7:0] beat_data(input int kind, input int k);
    case (kind)
      0:       return (k < E) ? 8'(k + 1) : (((k - E) % 5 == 0) ? 8'd1 : 8'd0);
      2:       return (k < E) ? 8'(k + 1) : 8'(k - E);
      default: return 8'($urandom);
    endcase
  endfunction

  // Offer beats [from, to) with random gaps; beat last_at carries s_last
  task automatic stream(input int kind, input int vprob, input int from, input int to,
                        input int last_at);
    int acc, guard;
    acc   = from;
    guard = 0;
    while (acc < to && guard < 2000) begin
      guard++;
      s_valid = ($urandom_range(99) < vprob);
      s_data  = s_valid ? beat_data(kind, acc) : 8'($urandom);
      s_last  = s_valid ? (acc == last_at) : 1'($urandom_range(1));
      if (s_valid && m_phase == 0) acc++;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (acc < to) begin
      compared++;
      mismatched++;
      $display("FAIL stream_timeout: accepted %0d beats, required %0d", acc, to);
    end
  endtask

  // Junk beats while the engine owns the operands must be ignored
  task automatic finish_engine(input int delay);
    for (int i = 0; i <= delay; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom_range(1));
      tick();
    end
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_row(input row_t r);
    int f0;
    f0 = fires_seen;
    stream(r.kind, r.vprob, 0, r.nbeats, r.last_at);
    if (r.fire != 0) begin
      finish_engine(r.delay);
    end else begin
      tick();
      tick();
    end
    check8("row_fires", 8'(fires_seen - f0), 8'(r.fire));
    check1("row_err", err, r.exp_err);
    check8("row_frame_cnt", frame_cnt, 8'(r.exp_cnt));
    if (r.clr) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check1("err_after_clr", err, 1'b0);
    end
  endtask

  initial begin
    rows[0] = '{0, 100,  31, 32,  5, 1, 1'b0, 1, 1'b0};
    rows[1] = '{0,  50,  31, 32, 20, 1, 1'b0, 2, 1'b0};
    rows[2] = '{2,  70,  31, 32,  3, 1, 1'b0, 3, 1'b0};
    rows[3] = '{1, 100,  10, 11,  0, 0, 1'b1, 3, 1'b0};
    rows[4] = '{1,  80,  31, 32,  2, 1, 1'b1, 4, 1'b1};
    rows[5] = '{1, 100,  -1, 32,  0, 0, 1'b1, 4, 1'b0};
    rows[6] = '{1,  60,  20, 21,  0, 0, 1'b1, 4, 1'b1};
    rows[7] = '{1,  50,  31, 32,  4, 1, 1'b0, 5, 1'b0};

    fires_seen = 0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'd0;
    mm_done = 1'b0;
    err_clr = 1'b0;
    model_reset();
    #2;
    check1("rst_s_ready", s_ready, 1'b1);
    check1("rst_mm_start", mm_start, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    check8("rst_frame_cnt", frame_cnt, 8'd0);
    check128("rst_a_flat", a_flat, 128'd0);
    check128("rst_b_flat", b_flat, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_row(rows[i]);
      if (i == 0) begin
        check8("a00", a_flat[7:0], 8'd1);
        check8("a33", a_flat[127:120], 8'd16);
        check128("b_identity", b_flat, 128'h01000000000100000000010000000001);
      end
      if (i == 2) begin
`ifdef LOADER_TRANSPOSE_B_EN
        check8("b01", b_flat[15:8], 8'd4);
        check8("b32", b_flat[119:112], 8'd11);
`else
        check8("b01", b_flat[15:8], 8'd1);
        check8("b32", b_flat[119:112], 8'd14);
`endif
      end
    end

    // Error and clear in the same cycle: the error must win
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 8'hAA;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    check1("set_wins", err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check1("clr_after_set", err, 1'b0);

    // Spurious done while loading B, then reset while waiting on the engine
    stream(1, 100, 0, 20, 31);
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    stream(1, 100, 20, 32, 31);
    tick();
    tick();
    check1("wait_busy", busy, 1'b1);
    check8("wait_frame_cnt", frame_cnt, 8'd6);
    rst = 1'b1;
    #2;
    check128("arst_a_flat", a_flat, 128'd0);
    check128("arst_b_flat", b_flat, 128'd0);
    check8("arst_frame_cnt", frame_cnt, 8'd0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_mm_start", mm_start, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check1("post_rst_ready", s_ready, 1'b1);
    run_row(rows[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
